// File: rtl/sram_ctrl_param.sv
// Parametrised single-port SRAM peripheral for the data-side bus.
// Decodes its own byte-address window, supports byte-lane writes, flags
// out-of-window or misaligned accesses, and returns every accepted request
// through a fixed READ_LAT-stage response pipeline so responses stay in order.
// A bulk-clear engine zeroes the array one word per cycle on command.
//
// Handshake: a request transfers on a rising edge where req && gnt. gnt depends
// only on the controller state (and is held low during reset), never on req.
// Every transferred request produces exactly one rsp_valid pulse READ_LAT
// cycles later; there is no response backpressure.
module sram_ctrl_param #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                READ_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  output logic                gnt,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  input  logic                clr,
  output logic                busy,
  output logic                state_dbg
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int AW1   = ADDR_W + 1;

  // Window size in bytes, one bit wider than the address so it never wraps.
  localparam logic [ADDR_W:0]   SPAN     = AW1'(DEPTH * BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic              misaligned;
  logic              addr_err;
  logic              wr_en;
  logic [ADDR_W:0]   offs;
  logic [IDX_W-1:0]  widx;
  logic [DATA_W-1:0] rd_data;

  logic              pipe_v [READ_LAT];
  logic              pipe_e [READ_LAT];
  logic [DATA_W-1:0] pipe_d [READ_LAT];

  // Address decode. An address below the base wraps the widened subtraction
  // to a value of at least 2**ADDR_W, so a single compare covers both bounds.
  assign offs       = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_range   = (offs < SPAN);
  assign misaligned = |(addr & OFF_MASK);
  assign addr_err   = !in_range || misaligned;
  assign widx       = IDX_W'(offs >> OFF_W);

  assign accept  = req && gnt;
  assign wr_en   = accept && we && !addr_err;
  // Only good reads carry array data; writes, errors and idle cycles carry 0.
  assign rd_data = (accept && !we && !addr_err) ? mem[widx] : '0;

  // State register: reset returns the controller to IDLE immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: clr starts a sweep from IDLE, the sweep ends after the last word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == IDX_W'(DEPTH - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: grant only in IDLE and never while reset is held.
  always_comb begin
    gnt  = 1'b0;
    busy = 1'b0;
    case (state)
      IDLE:    gnt  = reset;
      CLEAR:   busy = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = (state == CLEAR);

  // Clear counter: walks the array during CLEAR and sits at 0 otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end else begin
      clr_cnt <= '0;
    end
  end

  // Array update: the clear sweep and bus writes never coincide, since writes need gnt.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Response pipeline: every accepted request enters stage 0; reset drops all in-flight entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_e[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= accept;
      pipe_e[0] <= accept && addr_err;
      pipe_d[0] <= rd_data;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign rsp_valid = pipe_v[READ_LAT-1];
  assign rsp_err   = pipe_e[READ_LAT-1];
  assign rsp_rdata = pipe_d[READ_LAT-1];

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Bench for sram_ctrl_param: two instances (READ_LAT 1 and 3) share one
// stimulus stream; a word-array model plus a per-edge acceptance log gives
// the expected outputs of both every cycle.
module tb_sram_ctrl_param;

  localparam int          DW    = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          HN    = 4096;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- DUT signals
  logic          req;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   addr;
  logic [DW-1:0] wdata;
  logic          clr;

  logic          gnt1, rsp_valid1, rsp_err1, busy1, state_dbg1;
  logic [DW-1:0] rsp_rdata1;
  logic          gnt3, rsp_valid3, rsp_err3, busy3, state_dbg3;
  logic [DW-1:0] rsp_rdata3;

  sram_ctrl_param #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE), .READ_LAT(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt1), .we(we), .be(be),
    .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err1), .clr(clr), .busy(busy1), .state_dbg(state_dbg1)
  );

  sram_ctrl_param #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE), .READ_LAT(3)
  ) u_dut3 (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt3), .we(we), .be(be),
    .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3),
    .rsp_err(rsp_err3), .clr(clr), .busy(busy3), .state_dbg(state_dbg3)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // mem_m is the word array; clear_left counts words still to be zeroed by a
  // running clear; hist_* logs, per clock edge, what response that edge's
  // accepted request must eventually produce.
  logic [31:0] mem_m [DEPTH];
  int          clear_left = 0;
  int          cyc = 0;
  bit          acc_flag = 1'b0;
  bit          hist_v [HN];
  bit          hist_e [HN];
  logic [31:0] hist_d [HN];

  function automatic bit model_err(input logic [31:0] a);
    return (a < BASE) || (a >= BASE + 32'd64) || ((a % 4) != 0);
  endfunction

  task automatic model_reset();
    clear_left = 0;
    for (int i = 0; i < HN; i++) begin
      hist_v[i] = 1'b0;
      hist_e[i] = 1'b0;
      hist_d[i] = '0;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    model_reset();
    forever begin
      int s;
      int k;
      bit e;
      @(posedge clk);
      cyc++;
      s = cyc % HN;
      acc_flag  = 1'b0;
      hist_v[s] = 1'b0;
      hist_e[s] = 1'b0;
      hist_d[s] = '0;
      if (reset) begin
        if (req && clear_left == 0) begin
          acc_flag  = 1'b1;
          e         = model_err(addr);
          hist_v[s] = 1'b1;
          hist_e[s] = e;
          if (!e) begin
            k = int'((addr - BASE) / 4);
            if (we) begin
              for (int i = 0; i < 4; i++)
                if (be[i]) mem_m[k][8*i +: 8] = wdata[8*i +: 8];
            end else begin
              hist_d[s] = mem_m[k];
            end
          end
        end
        if (clear_left > 0) begin
          mem_m[DEPTH - clear_left] = '0;
          clear_left--;
        end else if (clr) begin
          clear_left = DEPTH;
        end
      end
    end
  end

  // ---------------------------------------------------------------- compare process
  task automatic check_rsp(input string nm, input int lat, input logic v,
                           input logic er, input logic [31:0] d);
    int e;
    int s;
    bit ev;
    bit ee;
    logic [31:0] ed;
    e  = cyc - lat + 1;
    ev = 1'b0;
    ee = 1'b0;
    ed = '0;
    if (e >= 1) begin
      s  = e % HN;
      ev = hist_v[s];
      ee = hist_e[s];
      ed = hist_d[s];
    end
    chk1({nm, "_valid"}, v, ev);
    chk1({nm, "_err"}, er, ee);
    chk({nm, "_rdata"}, d, ed);
  endtask

  initial begin
    forever begin
      logic exp_gnt;
      logic exp_busy;
      @(negedge clk);
      exp_gnt  = reset && (clear_left == 0);
      exp_busy = reset && (clear_left > 0);
      chk1("gnt1", gnt1, exp_gnt);
      chk1("gnt3", gnt3, exp_gnt);
      chk1("busy1", busy1, exp_busy);
      chk1("busy3", busy3, exp_busy);
      chk1("state_dbg1", state_dbg1, exp_busy);
      chk1("state_dbg3", state_dbg3, exp_busy);
      check_rsp("rsp1", 1, rsp_valid1, rsp_err1, rsp_rdata1);
      check_rsp("rsp3", 3, rsp_valid3, rsp_err3, rsp_rdata3);
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic c);
    bit got;
    got   = 1'b0;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
    clr   = c;
    for (int n = 0; n < 100 && !got; n++) begin
      @(posedge clk);
      #1;
      got = acc_flag;
    end
    chk1("req_accept", got, 1'b1);
    clr = 1'b0;
  endtask

  task automatic go_idle();
    req = 1'b0;
    clr = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #1;
    chk1("rst_gnt_now", gnt1, 1'b0);
    chk1("rst_busy_now", busy1, 1'b0);
    chk1("rst_valid1_now", rsp_valid1, 1'b0);
    chk1("rst_valid3_now", rsp_valid3, 1'b0);
    go_idle();
    step(2);
    reset = 1'b1;
    #1;
    chk1("gnt_after_release", gnt1, 1'b1);
  endtask

  // ---------------------------------------------------------------- main sequence
  logic [31:0] saved [DEPTH];

  initial begin
    int n_busy;
    int n_gntlo;
    logic [31:0] a;
    int k;

    reset = 1'b1;
    go_idle();
    we    = 1'b0;
    be    = '0;
    addr  = '0;
    wdata = '0;
    #1;
    reset = 1'b0;
    #1;
    chk1("reset_gnt", gnt1, 1'b0);
    chk1("reset_busy", busy1, 1'b0);
    chk1("reset_valid1", rsp_valid1, 1'b0);
    chk("reset_rdata1", rsp_rdata1, 32'h0);
    chk1("reset_err3", rsp_err3, 1'b0);
    step(2);
    reset = 1'b1;
    #1;
    chk1("gnt_first_cycle", gnt1, 1'b1);

    // Fill every word so the array contents are known.
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, BASE + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b0);

    // Full-word write then read back.
    do_req(1'b1, BASE, 32'hDEAD_BEEF, 4'hF, 1'b0);
    chk1("wr_rsp_valid", rsp_valid1, 1'b1);
    chk("wr_rsp_rdata", rsp_rdata1, 32'h0);
    do_req(1'b0, BASE, 32'h0, 4'h0, 1'b0);
    chk1("rd_rsp_valid", rsp_valid1, 1'b1);
    chk("rd_deadbeef", rsp_rdata1, 32'hDEAD_BEEF);

    // Byte-lane merge.
    do_req(1'b1, BASE + 32'h8, 32'h1122_3344, 4'hF, 1'b0);
    do_req(1'b1, BASE + 32'h8, 32'hAABB_CCDD, 4'h5, 1'b0);
    do_req(1'b0, BASE + 32'h8, 32'h0, 4'h0, 1'b0);
    chk("lane_read", rsp_rdata1, 32'h11BB_33DD);
    chk("lane_model", mem_m[2], 32'h11BB_33DD);

    // Address errors: below window, above window, misaligned; plus an erroring write.
    do_req(1'b0, 32'h0FFF_FFFC, 32'h0, 4'h0, 1'b0);
    chk1("err_below", rsp_err1, 1'b1);
    chk("err_below_rdata", rsp_rdata1, 32'h0);
    do_req(1'b0, 32'h1000_1000, 32'h0, 4'h0, 1'b0);
    chk1("err_above", rsp_err1, 1'b1);
    do_req(1'b0, 32'h1000_0002, 32'h0, 4'h0, 1'b0);
    chk1("err_misalign", rsp_err1, 1'b1);
    do_req(1'b1, 32'h1000_0006, 32'hFFFF_FFFF, 4'hF, 1'b0);
    chk1("err_write", rsp_err1, 1'b1);
    do_req(1'b0, BASE + 32'h4, 32'h0, 4'h0, 1'b0);
    chk1("err_mem_intact_err", rsp_err1, 1'b0);
    chk("err_mem_intact", rsp_rdata1, 32'hC0DE_0001);

    // Back-to-back reads through the three-stage instance.
    go_idle();
    step(4);
    do_req(1'b0, BASE + 32'h0, 32'h0, 4'h0, 1'b0);
    chk1("lat3_not_yet_a", rsp_valid3, 1'b0);
    do_req(1'b0, BASE + 32'h4, 32'h0, 4'h0, 1'b0);
    chk1("lat3_not_yet_b", rsp_valid3, 1'b0);
    do_req(1'b0, BASE + 32'h8, 32'h0, 4'h0, 1'b0);
    chk1("lat3_first_valid", rsp_valid3, 1'b1);
    chk("lat3_word0", rsp_rdata3, 32'hDEAD_BEEF);
    do_req(1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b0);
    go_idle();
    chk("lat3_word1", rsp_rdata3, 32'hC0DE_0001);
    step(1);
    chk("lat3_word2", rsp_rdata3, 32'h11BB_33DD);
    step(1);
    chk("lat3_word3", rsp_rdata3, 32'hC0DE_0003);
    step(1);
    chk1("lat3_done", rsp_valid3, 1'b0);

    // Bulk clear: busy and gnt-low for exactly DEPTH cycles, then all zero.
    step(3);
    clr = 1'b1;
    step(1);
    clr     = 1'b0;
    n_busy  = 0;
    n_gntlo = 0;
    for (int n = 0; n < 100; n++) begin
      if (busy1) n_busy++;
      if (!gnt1) n_gntlo++;
      if (!busy1) break;
      step(1);
    end
    chk("clear_busy_cycles", 32'(n_busy), 32'd16);
    chk("clear_gnt_low_cycles", 32'(n_gntlo), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      do_req(1'b0, BASE + 32'(4*i), 32'h0, 4'h0, 1'b0);
      chk("clear_readback", rsp_rdata1, 32'h0);
    end

    // Refill with random data, then reset with two reads in flight.
    for (int i = 0; i < DEPTH; i++) begin
      saved[i] = $urandom;
      do_req(1'b1, BASE + 32'(4*i), saved[i], 4'hF, 1'b0);
    end
    do_req(1'b0, BASE + 32'hC, 32'h0, 4'h0, 1'b0);
    do_req(1'b0, BASE + 32'h10, 32'h0, 4'h0, 1'b0);
    pulse_reset();
    for (int n = 0; n < 4; n++) begin
      chk1("no_stale_rsp3", rsp_valid3, 1'b0);
      step(1);
    end

    // Reset during a clear after five words have been zeroed.
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(5);
    chk1("mid_clear_busy", busy1, 1'b1);
    pulse_reset();
    do_req(1'b0, BASE + 32'h10, 32'h0, 4'h0, 1'b0);
    chk("partial_clear_w4", rsp_rdata1, 32'h0);
    do_req(1'b0, BASE + 32'h14, 32'h0, 4'h0, 1'b0);
    chk("partial_clear_w5", rsp_rdata1, saved[5]);
    for (int i = 0; i < DEPTH; i++) do_req(1'b0, BASE + 32'(4*i), 32'h0, 4'h0, 1'b0);
    chk("model_w0_zero", mem_m[0], 32'h0);
    chk("model_w15_kept", mem_m[15], saved[15]);

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      go_idle();
      step($urandom_range(0, 2));
      k = $urandom_range(0, 15);
      case ($urandom_range(0, 9))
        0:       a = BASE + 32'(4*k) + 32'($urandom_range(1, 3));
        1:       a = BASE + 32'd64 + 32'(4 * $urandom_range(0, 100));
        2:       a = BASE - 32'(4 * $urandom_range(1, 50));
        default: a = BASE + 32'(4*k);
      endcase
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             ($urandom_range(0, 39) == 0));
    end
    go_idle();
    step(25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of sequence, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_ctrl_param.md
# sram_ctrl_param

Parametrised single-port SRAM peripheral for the RISC processor's data-side bus. It supports configurable data width, depth, base address and read latency, plus byte-lane write enables and an address-error response. A hardware bulk-clear engine zeroes the array on command. It decodes its own address window, returns in-order fixed-latency responses, and sits behind the core's load/store unit, replacing the fixed 32-bit/4 KB memory.

## Interface
- DATA_W, 32: data width in bits; multiple of 8, at least 8.
- DEPTH, 1024: number of words; power of 2, at least 2.
- ADDR_W, 32: byte-address width.
- BASE_ADDR, 0: byte address of word 0; aligned to DEPTH*DATA_W/8.
- READ_LAT, 1: response latency in cycles; 1 to 4.
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (low = reset).
- req  in  1  request valid.
- gnt  out  1  request accepted this cycle when req&gnt.
- we  in  1  1 = write, 0 = read.
- be  in  DATA_W/8  byte-lane write enables; ignored on reads.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  write data.
- rsp_valid  out  1  response valid, one-cycle pulse per accepted request.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  address error flag, qualified by rsp_valid.
- clr  in  1  start bulk clear; sampled only in IDLE.
- busy  out  1  bulk clear in progress.

## Operation
- BYTES = DATA_W/8. OFF_W = clog2(BYTES). IDX_W = clog2(DEPTH).
- Request is in range when BASE_ADDR <= addr < BASE_ADDR + DEPTH*BYTES. Word index = (addr - BASE_ADDR)[OFF_W +: IDX_W].
- Error when out of range or addr[OFF_W-1:0] != 0. An error request does not access memory; its response is rsp_err=1, rsp_rdata=0.
- Write: each lane i with be[i]=1 updates bits [8i+7:8i] at the accepting edge. Lanes with be[i]=0 are unchanged. be=0 is a legal no-op write. Response: rsp_err=0, rsp_rdata=0.
- Read: the array is read at the accepting edge and the data is carried through the response pipeline. A read accepted the cycle after a write to the same word returns the new data.
- All responses, including writes and errors, traverse the same READ_LAT-stage pipeline, so responses stay in acceptance order. One request is accepted per cycle at full throughput. There is no response backpressure.
- FSM with two states:
  - IDLE: gnt=1, busy=0. If clr=1 at an edge, go to CLEAR with clear counter=0. A req accepted at that same edge is still serviced.
  - CLEAR: gnt=0, busy=1. Writes 0 to word[counter] each cycle and increments the counter. After writing word DEPTH-1, go to IDLE. Takes exactly DEPTH cycles. clr is ignored.
- In-flight pipeline responses keep draining during CLEAR.
- Reset asserted:
  - State goes to IDLE and the clear counter to 0.
  - All pipeline valid bits clear, so outstanding responses are dropped.
  - Outputs: gnt=0 while reset is low; rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Memory contents are not reset. A clear interrupted by reset leaves the array partially zeroed.

## Timing
- Request accepted at edge E0 gives rsp_valid high in the cycle after edge E0+READ_LAT-1. READ_LAT=1 means the response is visible the cycle immediately after acceptance.
- gnt is combinational from state only (not from req); it goes high the first cycle after reset deasserts.
- clr at edge C gives busy=1 from C through edge C+DEPTH. gnt=1 again after edge C+DEPTH.
- A write accepted at edge C lands before the clear and is therefore zeroed.
- Reset assertion acts immediately, without waiting for a clock edge. Deassertion is assumed synchronous to clk, and the first request can be accepted at the next edge.

## Test plan
- Defaults, READ_LAT=1: write 0xDEADBEEF with be=0xF to 0x0, then read 0x0. Required: write response rsp_valid with rdata=0, then read rsp_rdata=0xDEADBEEF one cycle after acceptance.
- Byte lanes: write 0x11223344 with be=0xF, then 0xAABBCCDD with be=0x5 to 0x8, then read 0x8. Required: 0x11BB33DD.
- Errors, BASE_ADDR=0x10000000: read 0x0FFFFFFC, read 0x10001000 and read 0x10000002. Required: each returns rsp_err=1, rdata=0. Memory unchanged.
- READ_LAT=3 with back-to-back reads of 4 distinct words. Required: 4 consecutive rsp_valid pulses, the first 3 cycles after the first acceptance, with data in order.
- Clear with DEPTH=16: fill all words, then pulse clr. Required: busy high for 16 cycles and gnt low for those 16 cycles. All reads afterwards return 0.
- Reset mid-operation: pull reset low with 2 responses in flight and a clear at counter 5. Required:
  - rsp_valid, busy and gnt drop to 0 immediately.
  - After release, words 0-4 read 0 and words 5-15 keep their old values.
  - No stale responses appear.
